usb_uvc_payload_gen: RTL and testbench
======================================

// Module: usb_uvc_payload_gen
// PURPOSE
//  Generates UVC isochronous payload packets (2-byte header + pixel bytes) for an IN endpoint, one packet per USB SOF.
//  Successor to the fixed camera packetiser: packet size, frame gap and format are parameters.
//  Pixel source uses a valid/ready stream; underrun and late-SOF are detected and the frame is aborted with header ERR.
//  Sits between the user pixel source and the usbfs core ep81 data/valid/ready port.
// PARAMETERS
//  FRAME_TYPE   "YUY2"  "YUY2": every payload byte from source; "MONO": Y from source, U/V inserted as 8'h80
//  FRAME_W      14'd320 frame width in pixels, even
//  FRAME_H      14'd240 frame height in pixels, even
//  PACKET_SIZE  10'd802 max packet bytes incl. header, 3..1023
//  GAP_PACKETS  8'd0    header-only packets sent after each frame end (completed or aborted)
//  UNDER_TMO    8'd16   consecutive cycles with pkt_ready=1 & vf_valid=0 in payload before underrun declared, >=1
// PORTS
//  clk            in   1  system clock, 60 MHz
//  rstn           in   1  asynchronous active-low reset
//  usb_sof        in   1  1-cycle pulse at each USB frame start
//  pkt_data       out  8  packet byte to endpoint
//  pkt_valid      out  1  pkt_data valid; deassertion after a last byte ends the packet
//  pkt_ready      in   1  endpoint accepts pkt_data this cycle
//  pkt_last       out  1  current pkt_data is the final byte of the packet
//  vf_sof         out  1  pulse: first header byte of a new video frame accepted
//  vf_abort       out  1  pulse: current frame aborted, source must resync at next vf_sof
//  vf_byte        in   8  pixel byte
//  vf_valid       in   1  vf_byte valid
//  vf_ready       out  1  vf_byte consumed this cycle (vf_valid & vf_ready)
//  cur_fid        out  1  FID of frame in progress
//  stat_err       out  1  sticky: any abort since reset
// BEHAVIOUR
//  Reset: pkt_valid/pkt_last/vf_sof/vf_abort/vf_ready/stat_err=0, cur_fid=0, pkt_data=0, FSM=IDLE, counters=0.
//  Derived (package): FRAME_BYTES=W*H*2; PAYLOAD=PACKET_SIZE-2; PKT_CNT=ceil(FRAME_BYTES/PAYLOAD);
//   LAST_PAY=FRAME_BYTES%PAYLOAD or PAYLOAD if 0. All arithmetic 32-bit unsigned.
//  FSM: IDLE -usb_sof-> HDR0 -acc-> HDR1 -acc-> PAY (payload packet) or DONE (header-only packet);
//   PAY -last byte acc-> DONE; DONE -> IDLE next cycle. acc = pkt_valid & pkt_ready.
//  HDR0 byte 8'h02. HDR1 byte {1'b1, err, 4'b0, eof, fid}; eof=1 on last packet of frame or on abort notice.
//  Packet kinds: normal (PACKET_SIZE bytes), last (LAST_PAY+2), gap/abort notice (2 bytes, pkt_last on HDR1).
//  Payload: YUY2 -> pkt_data=vf_byte, pkt_valid=vf_valid, vf_ready=pkt_ready (zero latency, combinational path).
//   MONO -> even payload bytes from source as above; odd bytes 8'h80, pkt_valid=1, vf_ready=0.
//  Header bytes: pkt_valid=1, independent of vf_valid. vf_sof pulses cycle after HDR0 acc when pcnt==0 & not gap.
//  Underrun: in PAY, pkt_ready=1 & source byte needed & vf_valid=0 for UNDER_TMO cycles -> packet ends immediately
//   (pkt_valid drops, short packet), vf_abort pulse, stat_err=1, abort_pend=1.
//  Late SOF: usb_sof in HDR0/HDR1/PAY -> same as underrun; that SOF is consumed (no new packet until next SOF).
//  usb_sof in DONE or coincident with final acc: honoured, FSM goes to HDR0 for the new packet.
//  abort_pend: next packet is header-only with err=1, eof=1; then fid toggles, pcnt=0, gap counter loaded.
//  Frame completion: last packet acc -> fid toggles, pcnt=0, gap counter=GAP_PACKETS; gap packets: err=0, eof=0.
//  pcnt wraps only via completion/abort; bcnt counts 0..size-1 within packet.
//  Reset mid-packet: all outputs return to reset values within same cycle (async), next packet starts a new frame, fid=0.
// STRUCTURE
//  Package usb_uvc_pkg: derived localparams above, BFH bit positions (EOH=7, ERR=6, EOF=1, FID=0), FSM state encoding.
//  One sub-module natural: usb_uvc_underrun_tmr (cycle counter, clear on vf_valid, fire at UNDER_TMO).
//  Remaining counters/FSM inline in this module.
// TESTING  (W=4, H=2, PACKET_SIZE=8 -> 16 frame bytes, PKT_CNT=3, LAST_PAY=4)
//  YUY2, vf_valid=1, pkt_ready=1, 3 SOFs -> packets 8,8,6 bytes; HDR1 = 8'h80,8'h80,8'h82; vf_sof once; then fid=1.
//  MONO, same -> 8 source bytes consumed per frame; payload odd bytes all 8'h80; same sizes and headers.
//  GAP_PACKETS=2 -> after frame, 2 SOFs yield 2-byte packets 02,80|fid; next SOF starts frame with vf_sof.
//  vf_valid low 16 cycles in 2nd packet -> short packet, vf_abort pulse; next packet 02,C3 (err,eof,fid=1); stat_err=1.
//  usb_sof asserted mid-payload -> same abort sequence; usb_sof same cycle as final acc -> normal next packet.
//  rstn pulsed mid-payload -> pkt_valid=0 immediately; next SOF sends 02,80 header and vf_sof pulse with fid=0.

Source files
------------

// File: rtl/usb_uvc_pkg.sv
// Shared constants, derived sizing helpers and FSM states for the UVC payload generator.
package usb_uvc_pkg;

  // Bit positions inside the second header byte (BFH)
  localparam int unsigned BFH_EOH = 7;
  localparam int unsigned BFH_ERR = 6;
  localparam int unsigned BFH_EOF = 1;
  localparam int unsigned BFH_FID = 0;

  localparam logic [7:0] HDR_LEN_BYTE = 8'h02;
  localparam logic [7:0] MONO_CHROMA  = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_PAY,
    ST_DONE
  } uvc_state_e;

  function automatic int unsigned uvc_frame_bytes(input int unsigned w, input int unsigned h);
    return w * h * 32'd2;
  endfunction

  function automatic int unsigned uvc_payload(input int unsigned psize);
    return psize - 32'd2;
  endfunction

  function automatic int unsigned uvc_pkt_cnt(input int unsigned fb, input int unsigned pay);
    return (fb + pay - 32'd1) / pay;
  endfunction

  function automatic int unsigned uvc_last_pay(input int unsigned fb, input int unsigned pay);
    return ((fb % pay) == 32'd0) ? pay : (fb % pay);
  endfunction

endpackage

// File: rtl/usb_uvc_underrun_tmr.sv
// Counts consecutive stalled payload cycles and fires on the UNDER_TMO-th one.
module usb_uvc_underrun_tmr #(
  parameter logic [7:0] UNDER_TMO = 8'd16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic stall_i,
  output logic fire_o
);

  logic [7:0] cnt_q, cnt_d;

  // Fire combinationally so the packet is cut on the same edge; any break in the stall restarts the count
  always_comb begin
    fire_o = stall_i && (cnt_q == (UNDER_TMO - 8'd1));
    cnt_d  = cnt_q;
    if (!stall_i || fire_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Stall counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/usb_uvc_payload_gen.sv
// UVC isochronous payload packetiser: one header+pixel packet per USB SOF, with underrun/late-SOF abort.
module usb_uvc_payload_gen
  import usb_uvc_pkg::*;
#(
  parameter              FRAME_TYPE  = "YUY2",
  parameter logic [13:0] FRAME_W     = 14'd320,
  parameter logic [13:0] FRAME_H     = 14'd240,
  parameter logic [9:0]  PACKET_SIZE = 10'd802,
  parameter logic [7:0]  GAP_PACKETS = 8'd0,
  parameter logic [7:0]  UNDER_TMO   = 8'd16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       usb_sof,
  output logic [7:0] pkt_data,
  output logic       pkt_valid,
  input  logic       pkt_ready,
  output logic       pkt_last,
  output logic       vf_sof,
  output logic       vf_abort,
  input  logic [7:0] vf_byte,
  input  logic       vf_valid,
  output logic       vf_ready,
  output logic       cur_fid,
  output logic       stat_err
);

  localparam int unsigned FRAME_BYTES = uvc_frame_bytes(32'(FRAME_W), 32'(FRAME_H));
  localparam int unsigned PAYLOAD     = uvc_payload(32'(PACKET_SIZE));
  localparam int unsigned PKT_CNT     = uvc_pkt_cnt(FRAME_BYTES, PAYLOAD);
  localparam int unsigned LAST_PAY    = uvc_last_pay(FRAME_BYTES, PAYLOAD);
  localparam bit          IS_MONO     = (FRAME_TYPE == "MONO");

  uvc_state_e  state_q, state_d;
  logic [9:0]  bcnt_q, bcnt_d;
  logic [31:0] pcnt_q, pcnt_d;
  logic [7:0]  gap_q, gap_d;
  logic        fid_q, fid_d;
  logic        abort_pend_q, abort_pend_d;
  logic        stat_err_q, stat_err_d;
  logic        vf_sof_q, vf_sof_d;
  logic        vf_abort_q, vf_abort_d;

  logic        hdr_only, last_pkt, need_src, stall, tmr_fire, acc, fin_acc, pay_last;
  logic [31:0] pay_len;
  logic [7:0]  hdr1_byte;

  usb_uvc_underrun_tmr #(
    .UNDER_TMO(UNDER_TMO)
  ) u_tmr (
    .clk_i  (clk),
    .rst_ni (rstn),
    .stall_i(stall),
    .fire_o (tmr_fire)
  );

  // Packet classification: the kind is fixed by registers that only change at packet end
  always_comb begin
    hdr_only  = abort_pend_q || (gap_q != 8'd0);
    last_pkt  = !hdr_only && (pcnt_q == (PKT_CNT - 32'd1));
    pay_len   = last_pkt ? LAST_PAY : PAYLOAD;
    pay_last  = (32'(bcnt_q) == (pay_len + 32'd1));
    need_src  = !IS_MONO || !bcnt_q[0];
    stall     = (state_q == ST_PAY) && pkt_ready && need_src && !vf_valid;
    hdr1_byte = '0;
    hdr1_byte[BFH_EOH] = 1'b1;
    hdr1_byte[BFH_ERR] = abort_pend_q;
    hdr1_byte[BFH_EOF] = abort_pend_q || last_pkt;
    hdr1_byte[BFH_FID] = fid_q;
  end

  // Endpoint-side outputs; payload passes straight through from the source
  always_comb begin
    pkt_data  = '0;
    pkt_valid = 1'b0;
    pkt_last  = 1'b0;
    vf_ready  = 1'b0;
    case (state_q)
      ST_HDR0: begin
        pkt_data  = HDR_LEN_BYTE;
        pkt_valid = 1'b1;
      end
      ST_HDR1: begin
        pkt_data  = hdr1_byte;
        pkt_valid = 1'b1;
        pkt_last  = hdr_only;
      end
      ST_PAY: begin
        pkt_last = pay_last;
        if (need_src) begin
          pkt_data  = vf_byte;
          pkt_valid = vf_valid;
          vf_ready  = pkt_ready;
        end else begin
          pkt_data  = MONO_CHROMA;
          pkt_valid = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign acc     = pkt_valid && pkt_ready;
  assign fin_acc = acc && pkt_last;

  // Next-state: a final accept wins over a coincident SOF (which then starts the next packet)
  always_comb begin
    state_d      = state_q;
    bcnt_d       = bcnt_q;
    pcnt_d       = pcnt_q;
    gap_d        = gap_q;
    fid_d        = fid_q;
    abort_pend_d = abort_pend_q;
    stat_err_d   = stat_err_q;
    vf_sof_d     = 1'b0;
    vf_abort_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (usb_sof) begin
          state_d = ST_HDR0;
          bcnt_d  = '0;
        end
      end
      ST_HDR0, ST_HDR1, ST_PAY: begin
        if (fin_acc) begin
          bcnt_d  = '0;
          state_d = usb_sof ? ST_HDR0 : ST_DONE;
          if (abort_pend_q) begin
            abort_pend_d = 1'b0;
            fid_d        = ~fid_q;
            pcnt_d       = '0;
            gap_d        = GAP_PACKETS;
          end else if (gap_q != 8'd0) begin
            gap_d = gap_q - 8'd1;
          end else if (last_pkt) begin
            fid_d  = ~fid_q;
            pcnt_d = '0;
            gap_d  = GAP_PACKETS;
          end else begin
            pcnt_d = pcnt_q + 32'd1;
          end
        end else if (usb_sof || tmr_fire) begin
          state_d      = ST_DONE;
          bcnt_d       = '0;
          vf_abort_d   = 1'b1;
          stat_err_d   = 1'b1;
          abort_pend_d = 1'b1;
        end else if (acc) begin
          bcnt_d   = bcnt_q + 10'd1;
          state_d  = (state_q == ST_HDR0) ? ST_HDR1 : ST_PAY;
          vf_sof_d = (state_q == ST_HDR0) && (pcnt_q == 32'd0) && !hdr_only;
        end
      end
      ST_DONE: begin
        bcnt_d  = '0;
        state_d = usb_sof ? ST_HDR0 : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      bcnt_q       <= '0;
      pcnt_q       <= '0;
      gap_q        <= '0;
      fid_q        <= 1'b0;
      abort_pend_q <= 1'b0;
      stat_err_q   <= 1'b0;
      vf_sof_q     <= 1'b0;
      vf_abort_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bcnt_q       <= bcnt_d;
      pcnt_q       <= pcnt_d;
      gap_q        <= gap_d;
      fid_q        <= fid_d;
      abort_pend_q <= abort_pend_d;
      stat_err_q   <= stat_err_d;
      vf_sof_q     <= vf_sof_d;
      vf_abort_q   <= vf_abort_d;
    end
  end

  assign vf_sof   = vf_sof_q;
  assign vf_abort = vf_abort_q;
  assign cur_fid  = fid_q;
  assign stat_err = stat_err_q;

endmodule

// File: tb/tb_usb_uvc_payload_gen.sv
// Bench for usb_uvc_payload_gen: a YUY2 instance (no gap) and a MONO instance (2 gap packets).
module tb_usb_uvc_payload_gen;

  localparam int W = 4, H = 2, PS = 8;
  localparam int FB = W * H * 2;
  localparam int PAY = PS - 2;
  localparam int NPKT = (FB + PAY - 1) / PAY;

  logic clk = 1'b0, rstn = 1'b0, usb_sof = 1'b0, pkt_ready = 1'b0, vf_valid = 1'b0;
  logic [7:0] vf_byte = '0;
  logic [7:0] y_data, m_data, o_data;
  logic y_valid, y_last, y_vsof, y_vabt, y_vrdy, y_fid, y_err;
  logic m_valid, m_last, m_vsof, m_vabt, m_vrdy, m_fido, m_erro;
  logic o_valid, o_last, o_vsof, o_vabt, o_vrdy, o_fid, o_err;
  int sel = 0;

  int vecs = 0, errs = 0;
  logic [7:0] src [4096];
  logic [7:0] got [$];
  int ptr = 0, exp_ptr = 0, n_stall = 0;
  bit m_fid, m_abort, m_err, cur_last, cur_fstart;
  int m_pcnt, m_gap, cur_nsrc;

  always #5 clk = ~clk;

  usb_uvc_payload_gen #(.FRAME_TYPE("YUY2"), .FRAME_W(14'd4), .FRAME_H(14'd2), .PACKET_SIZE(10'd8),
                        .GAP_PACKETS(8'd0), .UNDER_TMO(8'd16)) u_yuy2 (
    .clk(clk), .rstn(rstn), .usb_sof(usb_sof), .pkt_data(y_data), .pkt_valid(y_valid),
    .pkt_ready(pkt_ready), .pkt_last(y_last), .vf_sof(y_vsof), .vf_abort(y_vabt),
    .vf_byte(vf_byte), .vf_valid(vf_valid), .vf_ready(y_vrdy), .cur_fid(y_fid), .stat_err(y_err));

  usb_uvc_payload_gen #(.FRAME_TYPE("MONO"), .FRAME_W(14'd4), .FRAME_H(14'd2), .PACKET_SIZE(10'd8),
                        .GAP_PACKETS(8'd2), .UNDER_TMO(8'd16)) u_mono (
    .clk(clk), .rstn(rstn), .usb_sof(usb_sof), .pkt_data(m_data), .pkt_valid(m_valid),
    .pkt_ready(pkt_ready), .pkt_last(m_last), .vf_sof(m_vsof), .vf_abort(m_vabt),
    .vf_byte(vf_byte), .vf_valid(vf_valid), .vf_ready(m_vrdy), .cur_fid(m_fido), .stat_err(m_erro));

  assign o_data  = (sel == 1) ? m_data  : y_data;
  assign o_valid = (sel == 1) ? m_valid : y_valid;
  assign o_last  = (sel == 1) ? m_last  : y_last;
  assign o_vsof  = (sel == 1) ? m_vsof  : y_vsof;
  assign o_vabt  = (sel == 1) ? m_vabt  : y_vabt;
  assign o_vrdy  = (sel == 1) ? m_vrdy  : y_vrdy;
  assign o_fid   = (sel == 1) ? m_fido  : y_fid;
  assign o_err   = (sel == 1) ? m_erro  : y_err;

  function automatic int first_diff(input logic [7:0] a[$], input logic [7:0] b[$]);
    int n = (a.size() > b.size()) ? a.size() : b.size();
    for (int i = 0; i < n; i++)
      if (i >= a.size() || i >= b.size() || a[i] !== b[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] qb(input logic [7:0] q[$], input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return 8'hxx;
  endfunction

  // Reference model: packet content follows from frame position, gap and abort bookkeeping
  task automatic model_reset();
    m_fid = 0; m_abort = 0; m_err = 0; m_pcnt = 0; m_gap = 0; exp_ptr = ptr;
  endtask

  task automatic model_packet(output logic [7:0] q[$]);
    int n;
    q = {}; cur_nsrc = 0; cur_fstart = 0; cur_last = 0;
    q.push_back(8'h02);
    if (m_abort) q.push_back({2'b11, 4'b0, 1'b1, m_fid});
    else if (m_gap > 0) q.push_back({7'b1000000, m_fid});
    else begin
      cur_last = (m_pcnt == NPKT - 1);
      cur_fstart = (m_pcnt == 0);
      n = cur_last ? FB - m_pcnt * PAY : PAY;
      q.push_back({1'b1, 5'b0, cur_last, m_fid});
      for (int k = 0; k < n; k++) begin
        if (sel == 1 && (k % 2) == 1) q.push_back(8'h80);
        else begin q.push_back(src[(exp_ptr + cur_nsrc) % 4096]); cur_nsrc++; end
      end
    end
  endtask

  task automatic model_complete();
    int gcfg = (sel == 1) ? 2 : 0;
    if (m_abort) begin m_abort = 0; m_fid = ~m_fid; m_pcnt = 0; m_gap = gcfg; end
    else if (m_gap > 0) m_gap--;
    else if (cur_last) begin m_fid = ~m_fid; m_pcnt = 0; m_gap = gcfg; end
    else m_pcnt++;
    exp_ptr += cur_nsrc;
  endtask

  task automatic model_abort();
    m_abort = 1; m_err = 1; exp_ptr = ptr;
  endtask

  task automatic do_reset();
    rstn = 1'b0; usb_sof = 1'b0; pkt_ready = 1'b0; vf_valid = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    model_reset();
  endtask

  // Drives one packet exchange and collects accepted bytes; bounded by a cycle budget
  task automatic xfer(input bit do_sof, input int stall_at, input int sof_at, input bit sof_final,
                      input bit rnd, output bit ok, output int nv, output int na);
    bit fin = 0, inj = 0, abt = 0;
    got = {}; nv = 0; na = 0; n_stall = 0;
    if (do_sof) begin
      @(negedge clk); usb_sof = 1'b1; pkt_ready = 1'b0; vf_valid = 1'b0;
    end
    for (int cyc = 0; cyc < 150 && !fin && !abt; cyc++) begin
      @(negedge clk);
      usb_sof = 1'b0;
      pkt_ready = rnd ? ($urandom_range(3) != 0) : 1'b1;
      vf_valid = rnd ? ($urandom_range(2) != 0) : 1'b1;
      if (stall_at >= 0 && got.size() >= stall_at) begin vf_valid = 1'b0; pkt_ready = 1'b1; end
      if (sof_at >= 0 && !inj && got.size() == sof_at) begin usb_sof = 1'b1; pkt_ready = 1'b0; inj = 1; end
      vf_byte = src[ptr % 4096];
      #1;
      if (o_vsof) nv++;
      if (o_vabt) begin na++; abt = 1; end
      else if (stall_at >= 0 && got.size() >= stall_at && !o_valid) n_stall++;
      if (o_valid && pkt_ready) begin got.push_back(o_data); if (o_last) fin = 1; end
      if (o_vrdy && vf_valid) ptr++;
      if (fin && sof_final) usb_sof = 1'b1;
    end
    ok = fin;
    @(negedge clk); usb_sof = 1'b0; pkt_ready = 1'b0; vf_valid = 1'b0;
    #1;
    if (o_vsof) nv++;
    if (o_vabt) na++;
  endtask

  task automatic test_reset();
    rstn = 1'b0; pkt_ready = 1'b1; vf_valid = 1'b1;
    for (int s = 0; s < 2; s++) begin
      sel = s; #1;
      vecs++;
      if ({o_data, o_valid, o_last, o_vsof, o_vabt, o_vrdy, o_fid, o_err} !== 15'h0) begin
        errs++;
        $display("FAIL reset_outputs dut%0d: got %h required 0000", s,
                 {1'b0, o_data, o_valid, o_last, o_vsof, o_vabt, o_vrdy, o_fid, o_err});
      end
    end
    do_reset();
  endtask

  task automatic test_frames();
    logic [7:0] exp[$]; bit ok; int nv, na, d;
    sel = 0; do_reset();
    for (int p = 0; p < 2 * NPKT; p++) begin
      model_packet(exp);
      xfer(1'b1, -1, -1, 1'b0, 1'b1, ok, nv, na);
      d = first_diff(got, exp);
      vecs++;
      if (d >= 0 || !ok) begin errs++;
        $display("FAIL yuy2_pkt%0d: byte %0d got %h len %0d, required %h len %0d", p, d, qb(got, d), got.size(), qb(exp, d), exp.size()); end
      vecs++;
      if (nv !== int'(cur_fstart) || na !== 0) begin errs++;
        $display("FAIL yuy2_pulses%0d: vf_sof %0d vf_abort %0d, required %0d 0", p, nv, na, cur_fstart); end
      model_complete();
      vecs++;
      if (o_fid !== m_fid) begin errs++; $display("FAIL yuy2_fid%0d: got %b required %b", p, o_fid, m_fid); end
    end
    vecs++;
    if (ptr !== exp_ptr) begin errs++; $display("FAIL yuy2_consumed: got %0d required %0d", ptr, exp_ptr); end
  endtask

  task automatic test_mono_gap();
    logic [7:0] exp[$]; bit ok; int nv, na, d, p0;
    sel = 1; do_reset(); p0 = ptr;
    for (int p = 0; p < NPKT + 3; p++) begin
      model_packet(exp);
      xfer(1'b1, -1, -1, 1'b0, 1'b1, ok, nv, na);
      d = first_diff(got, exp);
      vecs++;
      if (d >= 0 || !ok) begin errs++;
        $display("FAIL mono_pkt%0d: byte %0d got %h len %0d, required %h len %0d", p, d, qb(got, d), got.size(), qb(exp, d), exp.size()); end
      vecs++;
      if (nv !== int'(cur_fstart) || na !== 0) begin errs++;
        $display("FAIL mono_pulses%0d: vf_sof %0d vf_abort %0d, required %0d 0", p, nv, na, cur_fstart); end
      model_complete();
      if (p == NPKT - 1) begin
        vecs++;
        if (ptr - p0 !== FB / 2) begin errs++; $display("FAIL mono_src_bytes: got %0d required %0d", ptr - p0, FB / 2); end
      end
    end
    vecs++;
    if (o_fid !== m_fid) begin errs++; $display("FAIL mono_fid: got %b required %b", o_fid, m_fid); end
  endtask

  task automatic test_underrun();
    logic [7:0] exp[$]; logic [7:0] pre[$]; bit ok; int nv, na, d;
    sel = 0; do_reset();
    for (int p = 0; p < NPKT + 1; p++) begin
      model_packet(exp);
      xfer(1'b1, -1, -1, 1'b0, 1'b1, ok, nv, na);
      d = first_diff(got, exp);
      vecs++;
      if (d >= 0 || !ok) begin errs++; $display("FAIL urun_pre%0d: byte %0d got %h required %h", p, d, qb(got, d), qb(exp, d)); end
      model_complete();
    end
    model_packet(exp);
    xfer(1'b1, 5, -1, 1'b0, 1'b1, ok, nv, na);
    pre = exp; while (pre.size() > 5) pre.pop_back();
    d = first_diff(got, pre);
    vecs++;
    if (d >= 0 || ok) begin errs++; $display("FAIL urun_short: byte %0d got %h len %0d, required %h len 5", d, qb(got, d), got.size(), qb(pre, d)); end
    vecs++;
    if (na !== 1) begin errs++; $display("FAIL urun_abort_pulse: got %0d required 1", na); end
    vecs++;
    if (n_stall !== 16) begin errs++; $display("FAIL urun_timeout: got %0d cycles required 16", n_stall); end
    model_abort();
    vecs++;
    if (o_err !== 1'b1) begin errs++; $display("FAIL urun_stat_err: got %b required 1", o_err); end
    for (int p = 0; p < 2; p++) begin
      model_packet(exp);
      xfer(1'b1, -1, -1, 1'b0, 1'b1, ok, nv, na);
      d = first_diff(got, exp);
      vecs++;
      if (d >= 0 || !ok || nv !== int'(cur_fstart)) begin errs++;
        $display("FAIL urun_after%0d: byte %0d got %h required %h vf_sof %0d", p, d, qb(got, d), qb(exp, d), nv); end
      model_complete();
    end
  endtask

  task automatic test_late_sof();
    logic [7:0] exp[$]; logic [7:0] pre[$]; bit ok; int nv, na, d;
    sel = 1; do_reset();
    model_packet(exp);
    xfer(1'b1, -1, 4, 1'b0, 1'b1, ok, nv, na);
    pre = exp; while (pre.size() > 4) pre.pop_back();
    d = first_diff(got, pre);
    vecs++;
    if (d >= 0 || ok || na !== 1) begin errs++;
      $display("FAIL late_sof_abort: byte %0d got %h len %0d vf_abort %0d, required %h len 4 vf_abort 1", d, qb(got, d), got.size(), na, qb(pre, d)); end
    model_abort();
    for (int p = 0; p < 4; p++) begin
      model_packet(exp);
      xfer(1'b1, -1, -1, 1'b0, 1'b1, ok, nv, na);
      d = first_diff(got, exp);
      vecs++;
      if (d >= 0 || !ok || nv !== int'(cur_fstart)) begin errs++;
        $display("FAIL late_sof_after%0d: byte %0d got %h required %h vf_sof %0d", p, d, qb(got, d), qb(exp, d), nv); end
      model_complete();
    end
    vecs++;
    if (o_err !== 1'b1) begin errs++; $display("FAIL late_sof_stat_err: got %b required 1", o_err); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp[$]; bit ok; int nv, na, d;
    sel = 0; do_reset();
    for (int p = 0; p < NPKT + 2; p++) begin
      model_packet(exp);
      xfer(p == 0, -1, -1, p != NPKT + 1, 1'b0, ok, nv, na);
      d = first_diff(got, exp);
      vecs++;
      if (d >= 0 || !ok || nv !== int'(cur_fstart) || na !== 0) begin errs++;
        $display("FAIL b2b_pkt%0d: byte %0d got %h required %h vf_sof %0d vf_abort %0d", p, d, qb(got, d), qb(exp, d), nv, na); end
      model_complete();
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp[$]; bit ok; int nv, na, d;
    sel = 0; do_reset();
    for (int p = 0; p < NPKT; p++) begin
      model_packet(exp);
      xfer(1'b1, -1, -1, 1'b0, 1'b1, ok, nv, na);
      model_complete();
    end
    @(negedge clk); usb_sof = 1'b1; pkt_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); usb_sof = 1'b0; pkt_ready = 1'b1; vf_valid = 1'b1; vf_byte = src[ptr % 4096];
      #1; if (o_vrdy && vf_valid) ptr++;
    end
    @(negedge clk); vf_byte = src[ptr % 4096]; #1;
    vecs++;
    if (o_valid !== 1'b1 || o_fid !== 1'b1) begin errs++; $display("FAIL rst_mid_pre: valid %b fid %b required 1 1", o_valid, o_fid); end
    rstn = 1'b0; #1;
    vecs++;
    if ({o_valid, o_last, o_vrdy, o_fid, o_err, o_data} !== 13'h0) begin errs++;
      $display("FAIL rst_mid_async: got %h required 0000", {3'b0, o_valid, o_last, o_vrdy, o_fid, o_err, o_data}); end
    @(negedge clk); rstn = 1'b1; pkt_ready = 1'b0; vf_valid = 1'b0;
    model_reset();
    model_packet(exp);
    xfer(1'b1, -1, -1, 1'b0, 1'b1, ok, nv, na);
    d = first_diff(got, exp);
    vecs++;
    if (d >= 0 || !ok || nv !== 1) begin errs++;
      $display("FAIL rst_mid_next: byte %0d got %h required %h vf_sof %0d required 1", d, qb(got, d), qb(exp, d), nv); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4096; i++) src[i] = 8'($urandom);
    test_reset();
    test_frames();
    test_mono_gap();
    test_underrun();
    test_late_sof();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
